// File: rtl/vram_arbiter_if.sv
// Requester and RAM-side bus for the VRAM arbiter; slave is the arbiter view,
// master is the environment (requesters plus the RAM instance).
interface vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [2:0]          req;
  logic [2:0]          we;
  logic [3*ADDR_W-1:0] addr;
  logic [3*DATA_W-1:0] wdata;
  logic [2:0]          gnt;
  logic [2:0]          rvalid;
  logic [DATA_W-1:0]   rdata;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_w_addr;
  logic [DATA_W-1:0]   ram_w_data;
  logic [ADDR_W-1:0]   ram_r_addr;
  logic [DATA_W-1:0]   ram_r_data;

  modport slave (
    input  req, we, addr, wdata, ram_r_data,
    output gnt, rvalid, rdata, ram_we, ram_w_addr, ram_w_data, ram_r_addr
  );

  modport master (
    output req, we, addr, wdata, ram_r_data,
    input  gnt, rvalid, rdata, ram_we, ram_w_addr, ram_w_data, ram_r_addr
  );
endinterface

// File: rtl/vram_arbiter.sv
// Three-port arbiter for a single-port VRAM: port 0 has priority, bounded by a
// starvation counter; ports 1/2 share a round-robin slot. Read data is registered.
//   rr_ptr | meaning
//   PORT_1 | port 1 wins the next 1-vs-2 tie
//   PORT_2 | port 2 wins the next 1-vs-2 tie
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  vram_arbiter_if.slave bus
);
  localparam int         CNT_W  = $clog2(STARVE_MAX + 2);
  localparam logic [1:0] PORT_1 = 2'd1;
  localparam logic [1:0] PORT_2 = 2'd2;

  logic [1:0]        rr_ptr;
  logic [CNT_W-1:0]  starve_cnt;
  logic [2:0]        rvalid_q;
  logic [DATA_W-1:0] rdata_q;

  logic [2:0]        gnt_c;
  logic [1:0]        sel;
  logic              gnt_any;
  logic              wait_lo;
  logic              at_limit;
  logic              rd_fire;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    gnt_c    = 3'b000;
    sel      = 2'd0;
    wait_lo  = bus.req[1] | bus.req[2];
    at_limit = (starve_cnt == CNT_W'(STARVE_MAX));
    // Reset low cancels any grant so nothing reaches the RAM in that cycle.
    if (!reset) begin
      gnt_c = 3'b000;
    end else if (bus.req[0] && !(wait_lo && at_limit)) begin
      gnt_c = 3'b001;
      sel   = 2'd0;
    end else if (bus.req[1] && bus.req[2]) begin
      sel   = rr_ptr;
      gnt_c = (rr_ptr == PORT_2) ? 3'b100 : 3'b010;
    end else if (bus.req[1]) begin
      gnt_c = 3'b010;
      sel   = PORT_1;
    end else if (bus.req[2]) begin
      gnt_c = 3'b100;
      sel   = PORT_2;
    end
  end

  always_comb begin
    gnt_any   = |gnt_c;
    sel_addr  = bus.addr[int'(sel)*ADDR_W +: ADDR_W];
    sel_wdata = bus.wdata[int'(sel)*DATA_W +: DATA_W];
    sel_we    = bus.we[sel];
    rd_fire   = gnt_any && !sel_we;
  end

  assign bus.gnt        = gnt_c;
  assign bus.ram_we     = gnt_any && sel_we;
  assign bus.ram_w_addr = gnt_any ? sel_addr  : '0;
  assign bus.ram_r_addr = gnt_any ? sel_addr  : '0;
  assign bus.ram_w_data = gnt_any ? sel_wdata : '0;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rvalid_q   <= 3'b000;
      rdata_q    <= '0;
      rr_ptr     <= PORT_1;
      starve_cnt <= '0;
    end else begin
      rvalid_q <= rd_fire ? gnt_c : 3'b000;
      if (rd_fire) rdata_q <= bus.ram_r_data;

      if (gnt_c[1])      rr_ptr <= PORT_2;
      else if (gnt_c[2]) rr_ptr <= PORT_1;

      // Count port-0 wins only while a low-priority port is actually waiting.
      if (gnt_c[0] && wait_lo) begin
        if (!at_limit) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates one shared single-port 32 KiB x 8 video/sim RAM (write port plus combinational read port) between three requesters: PPU fetch (port 0), CPU bus (port 1), OAM/DMA engine (port 2).
- Grants at most one access per clock and drives the RAM's write and read address/data.
- Returns registered read data one cycle after the grant.
- Sits between the requesters and the RAM instance in the top-level.

Parameters:
ADDR_W, 15, RAM address width
DATA_W, 8, RAM data width
STARVE_MAX, 4, consecutive port-0 grants allowed while port 1 or 2 waits; the next grant then goes to a waiting low-priority port

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets all state
req  input  3  per-port request; bit i = port i
we  input  3  per-port write enable, qualified by req
addr  input  3*ADDR_W  per-port address; port i at [i*ADDR_W +: ADDR_W]
wdata  input  3*DATA_W  per-port write data; port i at [i*DATA_W +: DATA_W]
gnt  output  3  one-hot grant, combinational, same cycle the access is presented to the RAM
rvalid  output  3  one-hot, registered; asserted the cycle after a granted read
rdata  output  DATA_W  registered read data, valid when any rvalid bit is 1
ram_we  output  1  RAM write enable
ram_w_addr  output  ADDR_W  RAM write address
ram_w_data  output  DATA_W  RAM write data
ram_r_addr  output  ADDR_W  RAM read address
ram_r_data  input  DATA_W  RAM combinational read data

Behaviour:
- Reset (reset==0 at posedge):
  - rvalid=0, rdata=0, rr_ptr=1 (port 1 favoured next), starve_cnt=0.
  - While reset is low, gnt=0 and ram_we=0 regardless of req.
- Requester handshake:
  - Port i raises req[i] with stable we/addr/wdata and holds them until it sees gnt[i]=1 at a posedge.
  - req[i] may drop, or present a new access, the cycle after the grant.
  - Dropping req[i] before the grant is a protocol violation; behaviour is undefined and not checked.
- Arbitration (combinational each cycle):
  - wait_lo = req[1] | req[2].
  - Port 0 wins if req[0] && !(wait_lo && starve_cnt==STARVE_MAX).
  - Otherwise a low-priority port is granted by round-robin: if both 1 and 2 request, grant rr_ptr; else grant whichever requests.
  - No request: gnt=0.
- RAM drive when port g is granted:
  - ram_r_addr = ram_w_addr = addr[g], ram_w_data = wdata[g], ram_we = we[g].
  - When idle: ram_we=0, addresses and data = 0.
- Round-robin pointer: on a posedge granting port 1, rr_ptr<=2; granting port 2, rr_ptr<=1; otherwise unchanged.
- Starvation counter, updated at posedge:
  - Port 0 granted while wait_lo: starve_cnt <= starve_cnt+1, saturating at STARVE_MAX.
  - Port 1 or 2 granted, or !wait_lo: starve_cnt <= 0.
- Read return:
  - Granted read (we[g]=0) at posedge N: rdata <= ram_r_data and rvalid <= onehot(g), visible in cycle N+1 for exactly one cycle.
  - Granted write or idle: rvalid <= 0; rdata holds its last value.
- Write latency: the RAM captures the write at the posedge ending the grant cycle. A read of the same address granted in the next cycle returns the new data.
- Back-to-back: one grant per cycle is sustainable, so a read every cycle yields rvalid every cycle.
- Reset mid-operation: a grant presented in the reset cycle is cancelled (ram_we=0), and no rvalid follows. Requesters must re-request after reset releases.
- Throughput bound: with port 0 requesting continuously, each waiting low-priority port is served within STARVE_MAX+2 cycles when one port waits, and 2*(STARVE_MAX+1) cycles when both wait.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=3'b111 -> gnt=0, ram_we=0, rvalid=0, rdata=0 throughout; first cycle after release grants port 0.
- Write then read: port 1 writes 0x5A to 0x0123, then next cycle reads 0x0123 -> gnt[1] on both cycles; rvalid=3'b010 with rdata=0x5A the cycle after the read grant.
- Round-robin: ports 1 and 2 request reads continuously, port 0 idle -> gnt alternates 010,100,010,100 starting with 010 after reset; rvalid follows one cycle behind.
- Starvation: port 0 and port 1 request continuously, STARVE_MAX=4 -> gnt pattern 001,001,001,001,010 repeating; starve_cnt returns to 0 after the port-1 grant.
- Simultaneous, one cycle: all three request with port 0 at STARVE_MAX already hit while port 1 and port 2 wait -> grant goes to rr_ptr's port, not port 0; port 0 is granted the next cycle.
- Reset mid-read: grant a port-2 read of 0x7FFF, assert reset=0 in that same cycle -> no rvalid the next cycle; rdata=0.
